// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//   Round-robin arbiter that shares one carry-lookahead adder between NREQ
//   requesters. A granted request's operands are captured into registers. The
//   shared adder adds them during CALC. The sum and carry-out return on a
//   single response channel, tagged with the requester index.
//
//   Ports
//     clk        : clock. All state updates happen on the rising edge.
//     rst_n      : asynchronous, active-low reset.
//     req_valid  : per-requester request valid                 [NREQ]
//     req_ready  : per-requester grant, at most one bit set    [NREQ]
//     req_a      : operand A, requester i at [i*DW +: DW]      [NREQ*DW]
//     req_b      : operand B, same packing as req_a            [NREQ*DW]
//     req_cin    : per-requester carry-in                      [NREQ]
//     rsp_valid  : response valid, held until rsp_ready
//     rsp_ready  : response consumer ready
//     rsp_id     : index of the requester that owns the response [IDW]
//     rsp_sum    : a + b + cin mod 2^DW                        [DW]
//     rsp_cout   : carry-out of the addition
//
// adder (sub-module)
//   Combinational DW-bit adder built from 4-bit carry-lookahead groups.
//   DW must be a multiple of 4.
//     a, b : operands [DW]
//     cin  : carry-in
//     sum  : [DW]
//     cout : carry-out
// ---------------------------------------------------------------------------

module adder #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] sum,
  output logic          cout
);

  localparam int NG = DW / 4;

  logic [DW-1:0] g;
  logic [DW-1:0] p;
  logic [DW-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Inside each 4-bit group, every carry comes straight from the group
  // carry-in. Group carries ripple from one group to the next.
  always_comb begin
    logic [3:0] gg;
    logic [3:0] pp;
    logic [3:0] cc;
    logic       gcar;
    c    = '0;
    gg   = '0;
    pp   = '0;
    cc   = '0;
    gcar = cin;
    for (int j = 0; j < NG; j++) begin
      gg    = g[4*j +: 4];
      pp    = p[4*j +: 4];
      cc[0] = gcar;
      cc[1] = gg[0] | (pp[0] & gcar);
      cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & gcar);
      cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
            | (pp[2] & pp[1] & pp[0] & gcar);
      gcar  = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
            | (pp[3] & pp[2] & pp[1] & gg[0])
            | (pp[3] & pp[2] & pp[1] & pp[0] & gcar);
      c[4*j +: 4] = cc;
    end
    cout = gcar;
  end

  assign sum = p ^ c;

endmodule

module adder_arbiter #(
  parameter int DW   = 32,
  parameter int NREQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*DW-1:0]         req_a,
  input  logic [NREQ*DW-1:0]         req_b,
  input  logic [NREQ-1:0]            req_cin,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [DW-1:0]              rsp_sum,
  output logic                       rsp_cout
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e             state_q,     state_d;
  logic [IDW-1:0]     ptr_q,       ptr_d;
  logic [DW-1:0]      op_a_q,      op_a_d;
  logic [DW-1:0]      op_b_q,      op_b_d;
  logic               op_cin_q,    op_cin_d;
  logic [IDW-1:0]     op_id_q,     op_id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q,    rsp_id_d;
  logic [DW-1:0]      rsp_sum_q,   rsp_sum_d;
  logic               rsp_cout_q,  rsp_cout_d;

  logic               gnt_found;
  logic [IDW-1:0]     gnt_id;
  logic [NREQ-1:0]    gnt_vec;
  logic [DW-1:0]      sel_a;
  logic [DW-1:0]      sel_b;
  logic               sel_cin;

  logic [DW-1:0]      add_sum;
  logic               add_cout;

  // The adder only ever sees registered operands. This keeps the request
  // inputs off the long carry path.
  adder #(.DW(DW)) u_adder (
    .a    (op_a_q),
    .b    (op_b_q),
    .cin  (op_cin_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Round-robin search without a rotator. The winner is the lowest valid
  // index at or above ptr. If there is none, the lowest valid index overall
  // wins, which covers the wrapped part of the search order.
  always_comb begin
    logic           hi_found;
    logic           lo_found;
    logic [IDW-1:0] hi_id;
    logic [IDW-1:0] lo_id;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !hi_found && (IDW'(i) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_id    = IDW'(i);
      end
      if (req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
      end
    end
    gnt_found = hi_found | lo_found;
    gnt_id    = hi_found ? hi_id : lo_id;
  end

  // Decode the grant and select the operands with fixed slices, so no
  // variable part-select is needed.
  always_comb begin
    gnt_vec = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_found && (IDW'(i) == gnt_id)) begin
        gnt_vec[i] = 1'b1;
        sel_a      = req_a[i*DW +: DW];
        sel_b      = req_b[i*DW +: DW];
        sel_cin    = req_cin[i];
      end
    end
  end

  // The grant is combinational from req_valid. It is forced low while reset
  // is asserted, because the state register is already IDLE during reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == S_IDLE)) begin
      req_ready = gnt_vec;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          op_cin_d = sel_cin;
          op_id_d  = gnt_id;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        rsp_sum_d   = add_sum;
        rsp_cout_d  = add_cout;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_HOLD;
        // The pointer wraps at NREQ rather than 2^IDW, so it never names a
        // requester that does not exist.
        if (op_id_q == IDW'(NREQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = op_id_q + IDW'(1);
        end
      end
      S_HOLD: begin
        // The response data registers keep their values after the handshake.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

endmodule
